// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, runs req/gnt/rvalid to instruction memory.
// Optional macro MISALIGN_TRAP_EN: reject misaligned fetches with a fetch_fault pulse.
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            fetch_start,
  input  logic            pc_write,
  input  logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic            busy,
  output logic            fetch_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state;
  logic            pend_valid;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] load_pc;
  logic [XLEN-1:0] start_pc;
  logic [XLEN-1:0] done_pc;
  logic            start_ok;

`ifdef MISALIGN_TRAP_EN
  assign load_pc  = pc_next;
  assign start_ok = (start_pc[1:0] == 2'b00);
`else
  assign load_pc  = pc_next & ~XLEN'(3);
  assign start_ok = 1'b1;
  assign fetch_fault = 1'b0;
`endif

  // A redirect in the same cycle as fetch_start takes effect before the fetch.
  assign start_pc  = pc_write ? load_pc : pc;
  // Latest redirect wins: a write in the rvalid cycle beats the pending one.
  assign done_pc   = pc_write ? load_pc : (pend_valid ? pend_pc : pc + XLEN'(4));

  assign imem_addr = pc;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      old_pc      <= RESET_PC;
      instr       <= NOP_INSTR;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      pend_valid  <= 1'b0;
      pend_pc     <= RESET_PC;
`ifdef MISALIGN_TRAP_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      instr_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      fetch_fault <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pc_write) pc <= load_pc;
          if (fetch_start) begin
            if (start_ok) begin
              state    <= REQ;
              imem_req <= 1'b1;
              busy     <= 1'b1;
            end else begin
`ifdef MISALIGN_TRAP_EN
              fetch_fault <= 1'b1;
`endif
            end
          end
        end
        REQ: begin
          if (pc_write) begin
            pend_valid <= 1'b1;
            pend_pc    <= load_pc;
          end
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            old_pc      <= pc;
            pc          <= done_pc;
            pend_valid  <= 1'b0;
            instr_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (pc_write) begin
            pend_valid <= 1'b1;
            pend_pc    <= load_pc;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand sequences, random fetches vs. a transaction model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        pc_write = 1'b0;
  logic [31:0] pc_next = '0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic        busy;
  logic        fetch_fault;

  instr_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .fetch_start(fetch_start), .pc_write(pc_write),
    .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .funct3(funct3), .instr_valid(instr_valid), .pc(pc), .old_pc(old_pc), .busy(busy),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_pc;

  typedef struct {
    logic [31:0] data;
    int          gd;
    int          rd;
    int          mode;   // 0 plain, 1 redirect while in flight, 2 redirect with fetch_start
    logic [31:0] tgt;
    logic [31:0] addr;
    logic [31:0] old;
    logic [31:0] npc;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] align(input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return a;
`else
    return a & ~32'h3;
`endif
  endfunction

  // Starts and ends just after a falling edge; drives the memory side with fixed delays.
  task automatic fetch(input logic [31:0] data, input int gd, input int rd, input int mode,
                       input logic [31:0] tgt, input logic [31:0] exp_addr,
                       input logic [31:0] exp_old, input logic [31:0] exp_pc);
    fetch_start = 1'b1;
    if (mode == 2) begin
      pc_write = 1'b1;
      pc_next  = tgt;
    end
    @(negedge clk);
    fetch_start = 1'b0;
    pc_write    = 1'b0;
    check("req_rise", imem_req, 1);
    check("req_addr", imem_addr, exp_addr);
    check("req_busy", busy, 1);
    check("no_fault", fetch_fault, 0);
    for (int k = 0; k < gd; k++) begin
      fetch_start = 1'b1;
      @(negedge clk);
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, exp_addr);
    end
    fetch_start = 1'b0;
    imem_gnt = 1'b1;
    if (mode == 1) begin
      pc_write = 1'b1;
      pc_next  = tgt ^ 32'h40;
    end
    @(negedge clk);
    imem_gnt = 1'b0;
    pc_write = 1'b0;
    check("req_drop", imem_req, 0);
    check("wait_busy", busy, 1);
    for (int k = 0; k < rd; k++) begin
      if (mode == 1 && k == 0) begin
        pc_write = 1'b1;
        pc_next  = tgt;
      end
      @(negedge clk);
      pc_write = 1'b0;
      check("early_valid", instr_valid, 0);
      check("wait_pc", pc, exp_addr);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    if (mode == 1 && rd == 0) begin
      pc_write = 1'b1;
      pc_next  = tgt;
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    pc_write    = 1'b0;
    imem_rdata  = $urandom;
    check("valid", instr_valid, 1);
    check("instr", instr, data);
    check("opcode", opcode, {25'd0, data[6:0]});
    check("funct3", funct3, {29'd0, data[14:12]});
    check("old_pc", old_pc, exp_old);
    check("pc", pc, exp_pc);
    check("idle_busy", busy, 0);
    @(negedge clk);
    check("pulse_end", instr_valid, 0);
    check("ir_hold", instr, data);
  endtask

  initial begin
    tbl[0] = '{32'h0050_0093, 0, 0, 0, 32'h0,   32'h0,   32'h0,   32'h4};
    tbl[1] = '{32'h0020_8133, 3, 2, 0, 32'h0,   32'h4,   32'h4,   32'h8};
    tbl[2] = '{32'h0000_a103, 0, 1, 1, 32'h100, 32'h8,   32'h8,   32'h100};
    tbl[3] = '{32'h00c0_006f, 1, 0, 1, 32'h200, 32'h100, 32'h100, 32'h200};
    tbl[4] = '{32'h40f5_5513, 2, 3, 2, 32'h300, 32'h300, 32'h300, 32'h304};
    tbl[5] = '{32'h0000_0013, 0, 0, 0, 32'h0,   32'h304, 32'h304, 32'h308};

    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_old_pc", old_pc, 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fetch_fault, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      fetch(tbl[i].data, tbl[i].gd, tbl[i].rd, tbl[i].mode, tbl[i].tgt,
            tbl[i].addr, tbl[i].old, tbl[i].npc);

    // PC wrap at the top of the address space.
    pc_write = 1'b1;
    pc_next  = 32'hFFFF_FFFC;
    @(negedge clk);
    pc_write = 1'b0;
    check("idle_redirect", pc, 32'hFFFF_FFFC);
    fetch(32'h0010_0073, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0);

    // Misaligned redirect then fetch.
    pc_write = 1'b1;
    pc_next  = 32'h102;
    @(negedge clk);
    pc_write = 1'b0;
`ifdef MISALIGN_TRAP_EN
    check("mis_pc", pc, 32'h102);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    check("fault_pulse", fetch_fault, 1);
    check("fault_no_req", imem_req, 0);
    check("fault_idle", busy, 0);
    @(negedge clk);
    check("fault_end", fetch_fault, 0);
    check("fault_no_req2", imem_req, 0);
    pc_write = 1'b1;
    pc_next  = 32'h104;
    @(negedge clk);
    pc_write = 1'b0;
`else
    check("mis_pc", pc, 32'h100);
    fetch(32'h0000_0513, 1, 1, 0, 32'h0, 32'h100, 32'h100, 32'h104);
`endif
    m_pc = 32'h104;
    check("model_sync", pc, m_pc);

    // Random transactions against a fetch-level model of the PC.
    for (int i = 0; i < 40; i++) begin
      int          mode;
      int          gd;
      int          rd;
      logic [31:0] tgt;
      logic [31:0] addr;
      logic [31:0] npc;
      mode = $urandom_range(0, 2);
      gd   = $urandom_range(0, 3);
      rd   = $urandom_range(0, 3);
      tgt  = $urandom;
`ifdef MISALIGN_TRAP_EN
      tgt[1:0] = 2'b00;
`endif
      addr = (mode == 2) ? align(tgt) : m_pc;
      npc  = (mode == 1) ? align(tgt) : addr + 32'd4;
      fetch($urandom, gd, rd, mode, tgt, addr, addr, npc);
      m_pc = npc;
    end

    // Reset during WAIT; a late rvalid must be ignored.
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_pc", pc, 32'h0);
    check("arst_instr", instr, 32'h0000_0013);
    @(negedge clk);
    reset_n     = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("late_rv_instr", instr, 32'h0000_0013);
    check("late_rv_valid", instr_valid, 0);
    check("late_rv_busy", busy, 0);
    check("late_rv_pc", pc, 32'h0);
    @(negedge clk);
    check("late_rv_valid2", instr_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
